// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signal bundle for mem_arbiter.
// The arbiter uses the slave view; caches plus RAM model use the master view.
interface mem_arbiter_if #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32
);
  logic [CPUS-1:0]        iREN;
  logic [CPUS*ADDR_W-1:0] iaddr;
  logic [CPUS-1:0]        iwait;
  logic [CPUS*ADDR_W-1:0] iload;
  logic [CPUS-1:0]        dREN;
  logic [CPUS-1:0]        dWEN;
  logic [CPUS*ADDR_W-1:0] daddr;
  logic [CPUS*ADDR_W-1:0] dstore;
  logic [CPUS-1:0]        dwait;
  logic [CPUS*ADDR_W-1:0] dload;
  logic                   ramREN;
  logic                   ramWEN;
  logic [ADDR_W-1:0]      ramaddr;
  logic [ADDR_W-1:0]      ramstore;
  logic [ADDR_W-1:0]      ramload;
  logic [1:0]             ramstate;
  logic                   ramerr;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Grants one icache/dcache request at a time to a single-port RAM; dcache beats icache.
// Define ARB_RR_EN for per-class round-robin CPU selection; otherwise lowest CPU index wins.
module mem_arbiter #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);

  localparam int         CPU_W      = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

  state_t                 state_r;
  state_t                 state_nx;
  logic                   gnt_d_r;
  logic [CPU_W-1:0]       gnt_cpu_r;
  logic                   ramerr_r;

  logic [CPUS-1:0]        d_req_s;
  logic                   any_d_s;
  logic                   any_i_s;
  logic [CPU_W-1:0]       ptr_i_s;
  logic [CPU_W-1:0]       ptr_d_s;
  logic [CPU_W-1:0]       win_cpu_s;
  logic [CPUS-1:0]        gnt_oh_s;
  logic                   sel_iren_s;
  logic                   sel_dren_s;
  logic                   sel_dwen_s;
  logic [ADDR_W-1:0]      sel_addr_s;
  logic [ADDR_W-1:0]      sel_store_s;
  logic                   is_write_s;
  logic                   live_s;
  logic                   ram_done_s;
  logic                   done_s;
  logic [ADDR_W-1:0]      load_data_s;
  logic [CPUS-1:0]        iwait_s;
  logic [CPUS-1:0]        dwait_s;
  logic [CPUS*ADDR_W-1:0] iload_s;
  logic [CPUS*ADDR_W-1:0] dload_s;
  logic                   ram_ren_s;
  logic                   ram_wen_s;
  logic [ADDR_W-1:0]      ram_addr_s;
  logic [ADDR_W-1:0]      ram_store_s;

  // First requester at or above ptr, else wrap to the lowest requester.
  function automatic logic [CPU_W-1:0] pick(input logic [CPUS-1:0] req, input logic [CPU_W-1:0] ptr);
    logic [CPU_W-1:0] sel;
    logic             found;
    sel   = '0;
    found = 1'b0;
    for (int c = 0; c < CPUS; c++) begin
      if (!found && req[c] && (CPU_W'(c) >= ptr)) begin
        sel   = CPU_W'(c);
        found = 1'b1;
      end
    end
    for (int c = 0; c < CPUS; c++) begin
      if (!found && req[c]) begin
        sel   = CPU_W'(c);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign d_req_s   = bus.dREN | bus.dWEN;
  assign any_d_s   = |d_req_s;
  assign any_i_s   = |bus.iREN;
  assign win_cpu_s = any_d_s ? pick(d_req_s, ptr_d_s) : pick(bus.iREN, ptr_i_s);

`ifdef ARB_RR_EN
  logic [CPU_W-1:0] ptr_i_r;
  logic [CPU_W-1:0] ptr_d_r;
  logic [CPU_W-1:0] ptr_next_s;

  assign ptr_next_s = (gnt_cpu_r == CPU_W'(CPUS - 1)) ? '0 : gnt_cpu_r + CPU_W'(1);

  // Round-robin pointers move only on a completed grant; aborts leave them alone.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr_i_r <= '0;
      ptr_d_r <= '0;
    end else if (done_s && gnt_d_r) begin
      ptr_d_r <= ptr_next_s;
    end else if (done_s) begin
      ptr_i_r <= ptr_next_s;
    end
  end

  assign ptr_i_s = ptr_i_r;
  assign ptr_d_s = ptr_d_r;
`else
  assign ptr_i_s = '0;
  assign ptr_d_s = '0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Winner is latched in IDLE and held for the whole SERVE phase.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      gnt_d_r   <= 1'b0;
      gnt_cpu_r <= '0;
    end else if ((state_r == IDLE) && (any_d_s || any_i_s)) begin
      gnt_d_r   <= any_d_s;
      gnt_cpu_r <= win_cpu_s;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ramerr_r <= 1'b0;
    end else if (done_s && (bus.ramstate == RAM_ERROR)) begin
      ramerr_r <= 1'b1;
    end
  end

  // Next-state logic: a dropped request aborts, ACCESS/ERROR completes.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (any_d_s || any_i_s) state_nx = SERVE;
        else                    state_nx = IDLE;
      end
      SERVE: begin
        if (!live_s || ram_done_s) state_nx = IDLE;
        else                       state_nx = SERVE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Mux the granted requester's live request, address and store data.
  always_comb begin
    gnt_oh_s    = '0;
    sel_iren_s  = 1'b0;
    sel_dren_s  = 1'b0;
    sel_dwen_s  = 1'b0;
    sel_addr_s  = '0;
    sel_store_s = '0;
    for (int k = 0; k < CPUS; k++) begin
      gnt_oh_s[k] = (gnt_cpu_r == CPU_W'(k));
      sel_iren_s  = sel_iren_s | (gnt_oh_s[k] & bus.iREN[k]);
      sel_dren_s  = sel_dren_s | (gnt_oh_s[k] & bus.dREN[k]);
      sel_dwen_s  = sel_dwen_s | (gnt_oh_s[k] & bus.dWEN[k]);
      sel_addr_s  = sel_addr_s | ({ADDR_W{gnt_oh_s[k]}} &
                    (gnt_d_r ? bus.daddr[k*ADDR_W +: ADDR_W] : bus.iaddr[k*ADDR_W +: ADDR_W]));
      sel_store_s = sel_store_s | ({ADDR_W{gnt_oh_s[k] & gnt_d_r}} & bus.dstore[k*ADDR_W +: ADDR_W]);
    end
  end

  assign is_write_s  = gnt_d_r & sel_dwen_s;
  assign live_s      = gnt_d_r ? (sel_dren_s | sel_dwen_s) : sel_iren_s;
  assign ram_done_s  = (bus.ramstate == RAM_ACCESS) || (bus.ramstate == RAM_ERROR);
  assign done_s      = (state_r == SERVE) && live_s && ram_done_s;
  assign load_data_s = ((bus.ramstate == RAM_ACCESS) && !is_write_s) ? bus.ramload : '0;

  // Output logic: the wait release has to land in the ACCESS cycle itself, so it stays combinational.
  always_comb begin
    iwait_s     = '1;
    dwait_s     = '1;
    iload_s     = '0;
    dload_s     = '0;
    ram_ren_s   = 1'b0;
    ram_wen_s   = 1'b0;
    ram_addr_s  = '0;
    ram_store_s = '0;
    if (state_r == SERVE) begin
      ram_addr_s  = sel_addr_s;
      ram_store_s = sel_store_s;
      ram_ren_s   = live_s & ~is_write_s;
      ram_wen_s   = live_s & is_write_s;
    end else begin
      ram_addr_s  = '0;
      ram_store_s = '0;
    end
    for (int k = 0; k < CPUS; k++) begin
      dwait_s[k] = ~(done_s & gnt_d_r & gnt_oh_s[k]);
      iwait_s[k] = ~(done_s & ~gnt_d_r & gnt_oh_s[k]);
      dload_s[k*ADDR_W +: ADDR_W] = {ADDR_W{~dwait_s[k]}} & load_data_s;
      iload_s[k*ADDR_W +: ADDR_W] = {ADDR_W{~iwait_s[k]}} & load_data_s;
    end
  end

  assign bus.iwait    = iwait_s;
  assign bus.dwait    = dwait_s;
  assign bus.iload    = iload_s;
  assign bus.dload    = dload_s;
  assign bus.ramREN   = ram_ren_s;
  assign bus.ramWEN   = ram_wen_s;
  assign bus.ramaddr  = ram_addr_s;
  assign bus.ramstore = ram_store_s;
  assign bus.ramerr   = ramerr_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  localparam int CPUS = 2;
  localparam int AW   = 32;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if #(.CPUS(CPUS), .ADDR_W(AW)) bus();
  mem_arbiter #(.CPUS(CPUS), .ADDR_W(AW)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  always #5 CLK = ~CLK;

  // model: one outstanding grant (class, cpu), per-class pointers, sticky error
  bit              m_busy;
  bit              m_cls;
  bit              m_err;
  bit              m_live;
  bit              m_done;
  int              m_cpu;
  int              m_ptr [2];
  logic [CPUS-1:0] seen_iwait;
  logic [CPUS-1:0] seen_dwait;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int choose(input logic [CPUS-1:0] req, input int start);
    for (int off = 0; off < CPUS; off++)
      if (req[(start + off) % CPUS]) return (start + off) % CPUS;
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_err = 1'b0; m_ptr[0] = 0; m_ptr[1] = 0;
  endtask

  task automatic model_check();
    logic [CPUS-1:0]    e_iw, e_dw;
    logic [CPUS*AW-1:0] e_il, e_dl;
    logic               e_ren, e_wen, wr;
    logic [AW-1:0]      e_addr, e_store, data;
    e_iw = '1; e_dw = '1; e_il = '0; e_dl = '0; e_ren = 1'b0; e_wen = 1'b0;
    e_addr = '0; e_store = '0; wr = 1'b0;
    m_live = 1'b0; m_done = 1'b0;
    if (m_busy) begin
      m_live  = m_cls ? (bus.dREN[m_cpu] | bus.dWEN[m_cpu]) : bus.iREN[m_cpu];
      wr      = m_cls && bus.dWEN[m_cpu];
      e_addr  = m_cls ? bus.daddr[m_cpu*AW +: AW] : bus.iaddr[m_cpu*AW +: AW];
      e_store = bus.dstore[m_cpu*AW +: AW];
      e_ren   = m_live && !wr;
      e_wen   = m_live && wr;
      m_done  = m_live && (bus.ramstate >= 2'd2);
      if (m_done) begin
        data = (bus.ramstate == 2'd2 && !wr) ? bus.ramload : '0;
        if (m_cls) begin e_dw[m_cpu] = 1'b0; e_dl[m_cpu*AW +: AW] = data; end
        else       begin e_iw[m_cpu] = 1'b0; e_il[m_cpu*AW +: AW] = data; end
      end
      chk("m_ramaddr", bus.ramaddr, e_addr);
    end
    if (e_wen) chk("m_ramstore", bus.ramstore, e_store);
    chk("m_iwait", bus.iwait, e_iw);
    chk("m_dwait", bus.dwait, e_dw);
    chk("m_iload", bus.iload, e_il);
    chk("m_dload", bus.dload, e_dl);
    chk("m_ramREN", bus.ramREN, e_ren);
    chk("m_ramWEN", bus.ramWEN, e_wen);
    chk("m_ramerr", bus.ramerr, m_err);
    seen_iwait = bus.iwait;
    seen_dwait = bus.dwait;
  endtask

  task automatic model_advance();
    logic [CPUS-1:0] dreq;
    dreq = bus.dREN | bus.dWEN;
    if (!m_busy) begin
      if (dreq != '0) begin m_busy = 1'b1; m_cls = 1'b1; m_cpu = choose(dreq, m_ptr[1]); end
      else if (bus.iREN != '0) begin m_busy = 1'b1; m_cls = 1'b0; m_cpu = choose(bus.iREN, m_ptr[0]); end
    end else if (!m_live) begin
      m_busy = 1'b0;
    end else if (m_done) begin
      m_busy = 1'b0;
      if (RR) m_ptr[m_cls] = (m_cpu + 1) % CPUS;
      if (bus.ramstate == 2'd3) m_err = 1'b1;
    end
  endtask

  task automatic sample();
    @(negedge CLK);
    model_check();
  endtask

  task automatic advance();
    model_advance();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = '0; bus.ramstate = 2'd0;
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  initial begin
    int            kind, r, expc;
    logic [CPUS-1:0] emask;

    // reset with every request asserted
    clear_inputs();
    nRST = 1'b0;
    model_reset();
    bus.iREN = '1; bus.dREN = '1; bus.dWEN = '1;
    bus.iaddr = {32'h1111_1111, 32'h2222_2222}; bus.daddr = {32'h3333_3333, 32'h4444_4444};
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_iwait", bus.iwait, 64'h3);
    chk("rst_dwait", bus.dwait, 64'h3);
    chk("rst_ramREN", bus.ramREN, 64'h0);
    chk("rst_ramWEN", bus.ramWEN, 64'h0);
    chk("rst_ramaddr", bus.ramaddr, 64'h0);
    chk("rst_ramerr", bus.ramerr, 64'h0);
    clear_inputs();
    nRST = 1'b1;

    // icache fill: two BUSY cycles then ACCESS
    bus.iREN[0] = 1'b1; bus.iaddr[31:0] = 32'h0000_0040;
    sample(); chk("fill_idle_ren", bus.ramREN, 64'h0); advance();
    bus.ramstate = 2'd1;
    sample(); chk("fill_ren", bus.ramREN, 64'h1); chk("fill_addr", bus.ramaddr, 64'h40);
    chk("fill_busy_wait", bus.iwait[0], 64'h1); advance();
    sample(); chk("fill_busy2_wait", bus.iwait[0], 64'h1); advance();
    bus.ramstate = 2'd2; bus.ramload = 32'hDEAD_BEEF;
    sample(); chk("fill_wait", bus.iwait[0], 64'h0); chk("fill_load", bus.iload[31:0], 64'hDEAD_BEEF); advance();
    bus.iREN[0] = 1'b0; bus.ramstate = 2'd0;
    sample(); chk("fill_after_wait", bus.iwait[0], 64'h1); chk("fill_after_load", bus.iload[31:0], 64'h0); advance();

    // dcache write beats a simultaneous icache read
    bus.iREN[0] = 1'b1; bus.iaddr[31:0] = 32'h44;
    bus.dWEN[0] = 1'b1; bus.daddr[31:0] = 32'h80; bus.dstore[31:0] = 32'h1234;
    bus.ramstate = 2'd2; bus.ramload = 32'h5555_AAAA;
    sample(); advance();
    sample(); chk("pri_wen", bus.ramWEN, 64'h1); chk("pri_store", bus.ramstore, 64'h1234);
    chk("pri_addr", bus.ramaddr, 64'h80); chk("pri_dwait", bus.dwait[0], 64'h0);
    chk("pri_iwait", bus.iwait[0], 64'h1); advance();
    bus.dWEN[0] = 1'b0;
    sample(); chk("pri_gap_ren", bus.ramREN, 64'h0); chk("pri_gap_wen", bus.ramWEN, 64'h0); advance();
    sample(); chk("pri_i_ren", bus.ramREN, 64'h1); chk("pri_i_addr", bus.ramaddr, 64'h44);
    chk("pri_i_wait", bus.iwait[0], 64'h0); advance();
    bus.iREN[0] = 1'b0;
    sample(); advance();

    // two icaches held high: alternate with round-robin, CPU0 only with fixed priority
    apply_reset();
    bus.iREN = 2'b11; bus.iaddr = {32'h0000_0B00, 32'h0000_0A00}; bus.ramstate = 2'd2;
    for (int k = 0; k < 4; k++) begin
      sample(); advance();
      sample();
      expc = RR ? (k % 2) : 0;
      emask = 2'b11; emask[expc] = 1'b0;
      chk("arb_iwait", bus.iwait, emask);
      advance();
    end
    bus.iREN = '0;
    sample(); advance();

    // abort during BUSY, then ERROR completion
    bus.dREN[1] = 1'b1; bus.daddr[63:32] = 32'h100; bus.ramstate = 2'd1;
    sample(); advance();
    sample(); chk("abort_ren_before", bus.ramREN, 64'h1); advance();
    bus.dREN[1] = 1'b0;
    sample(); chk("abort_ren", bus.ramREN, 64'h0); chk("abort_dwait", bus.dwait[1], 64'h1); advance();
    bus.iREN[1] = 1'b1; bus.iaddr[63:32] = 32'h200; bus.ramstate = 2'd3; bus.ramload = 32'hCAFE_F00D;
    sample(); chk("abort_idle_ren", bus.ramREN, 64'h0); advance();
    sample(); chk("err_iwait", bus.iwait[1], 64'h0); chk("err_iload", bus.iload[63:32], 64'h0);
    chk("err_flag_same", bus.ramerr, 64'h0); advance();
    bus.iREN[1] = 1'b0; bus.ramstate = 2'd0;
    sample(); chk("err_flag_next", bus.ramerr, 64'h1); advance();

    // reset during BUSY drops strobes with no clock edge
    bus.iREN[0] = 1'b1; bus.iaddr[31:0] = 32'h300; bus.ramstate = 2'd1;
    sample(); advance();
    sample(); chk("mrst_ren_before", bus.ramREN, 64'h1);
    #2 nRST = 1'b0;
    #1;
    chk("mrst_ren", bus.ramREN, 64'h0);
    chk("mrst_iwait", bus.iwait, 64'h3);
    chk("mrst_dwait", bus.dwait, 64'h3);
    model_reset();
    @(posedge CLK);
    #1 nRST = 1'b1;
    sample(); chk("mrst_idle_ren", bus.ramREN, 64'h0); chk("mrst_err", bus.ramerr, 64'h0); advance();
    bus.ramstate = 2'd2; bus.ramload = 32'h0BAD_F00D;
    sample(); chk("mrst_rearb_wait", bus.iwait[0], 64'h0); chk("mrst_rearb_load", bus.iload[31:0], 64'h0BAD_F00D); advance();
    bus.iREN[0] = 1'b0;

    // randomized traffic, requesters hold until released (dcache may abort)
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < CPUS; c++) begin
        if (bus.iREN[c]) begin
          if (!seen_iwait[c]) bus.iREN[c] = 1'b0;
        end else if ($urandom_range(99) < 30) begin
          bus.iREN[c] = 1'b1; bus.iaddr[c*AW +: AW] = $urandom;
        end
        if (bus.dREN[c] | bus.dWEN[c]) begin
          if (!seen_dwait[c] || $urandom_range(99) < 3) begin bus.dREN[c] = 1'b0; bus.dWEN[c] = 1'b0; end
        end else if ($urandom_range(99) < 25) begin
          kind = $urandom_range(2);
          bus.dREN[c] = (kind != 1); bus.dWEN[c] = (kind != 0);
          bus.daddr[c*AW +: AW] = $urandom; bus.dstore[c*AW +: AW] = $urandom;
        end
      end
      r = $urandom_range(99);
      bus.ramstate = (r < 10) ? 2'd0 : (r < 50) ? 2'd1 : (r < 90) ? 2'd2 : 2'd3;
      bus.ramload = $urandom;
      sample();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
